vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port synchronous tile RAM between two users: the VGA scan-out path (reads one tile colour per pixel tick) and the game-logic writer (tile updates through a small write FIFO).
- Also sequences a whole-screen clear command.
- Sits between the sync generator (p_tick, video_on, pixel_x/y) and the RGB output register.
- Produces the pixel colour for the colour DAC outputs.

Parameters:
- TILE_SHIFT, 5, log2 of tile edge in pixels (32x32 tiles).
- TILES_X, 20, tiles per row.
- TILES_Y, 15, tile rows. TILES = TILES_X*TILES_Y = 300.
- ADDR_W, 9, RAM address width.
- DATA_W, 3, tile colour width (r,g,b bits).
- FIFO_DEPTH, 4, write FIFO entries (power of 2).
- MAX_WAIT, 8, consecutive denied cycles before a write pre-empts a display slot.
- CLEAR_VALUE, 0, colour written by clear.

Ports:
- clock_50  in  1  system clock.
- reset_key  in  1  reset, asynchronous, active-low.
- p_tick  in  1  pixel tick from sync generator.
- video_on  in  1  visible-area flag.
- pixel_x  in  10  current column.
- pixel_y  in  10  current row.
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept.
- wr_addr  in  ADDR_W  tile index.
- wr_data  in  DATA_W  tile colour.
- clear_req  in  1  one-cycle clear command.
- clear_busy  out  1  drain/clear in progress.
- ram_addr  out  ADDR_W  RAM address (combinational).
- ram_we  out  1  RAM write enable (combinational).
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address.
- pix_rgb  out  DATA_W  registered pixel colour.
- underrun_cnt  out  8  saturating count of pre-empted display slots.

Behaviour:
- Reset (reset_key=0, async):
  - pix_rgb=0, underrun_cnt=0, clear_busy=0.
  - FIFO empty, so wr_ready=1. FSM=IDLE, wait_cnt=0, clear pointer=0.
  - ram_we=0.
  - Reset mid-clear aborts the clear; no resume.
- Slot types, one RAM access per cycle:
  - Display slot: p_tick=1 and video_on=1. ram_addr = (pixel_y>>TILE_SHIFT)*TILES_X + (pixel_x>>TILE_SHIFT), ram_we=0.
  - Free slot: every other cycle.
- Display latency:
  - Read issued in cycle t; pix_rgb<=ram_rdata at end of t+1.
  - If p_tick=1 and video_on=0 in cycle t, pix_rgb<=0 at end of t+1.
  - pix_rgb holds between updates.
- Write source in a free slot, in priority order:
  1. CLEAR FSM.
  2. FIFO head (pop).
  3. Nothing, in which case ram_we=0.
- Out-of-range write: a FIFO entry with wr_addr >= TILES is popped with ram_we=0 (dropped silently).
- Starvation guard:
  - wait_cnt increments each cycle a write is pending but not granted. It resets to 0 on any grant.
  - When wait_cnt == MAX_WAIT, the next display slot is given to the writer.
  - In that case pix_rgb repeats its previous value (no update at t+1) and underrun_cnt increments, saturating at 255.
- FIFO:
  - wr_ready = !full && !clear_busy.
  - Push on wr_valid && wr_ready.
  - Push and pop in the same cycle are both allowed.
  - No bypass: data pushed in cycle t can be written no earlier than t+1. FIFO order is preserved.
- FSM states:
  - IDLE -> DRAIN on clear_req if FIFO non-empty; IDLE -> CLEAR on clear_req if FIFO empty.
  - DRAIN -> CLEAR when FIFO becomes empty.
  - CLEAR writes CLEAR_VALUE to addresses 0..TILES-1, one per granted slot. After address TILES-1 is written, go to IDLE next cycle.
  - clear_busy=1 in DRAIN and CLEAR.
  - clear_req while busy is ignored.
- Arithmetic: tile-index computation is unsigned and truncated to ADDR_W. The multiply by TILES_X is a constant multiply.

Test Plan:
- Reset then idle with p_tick every 2nd cycle, video_on=1, RAM preloaded tile0=5 -> pix_rgb=5, 2 cycles after each p_tick; ram_we never 1.
- Push 4 writes (addr 21, data 3, etc.) with p_tick alternating -> all written in free cycles in order; wr_ready=0 while 4 held; pixel (32,32) later shows 3.
- Tie p_tick=1, video_on=1 constantly, one pending write -> write granted exactly after 8 denied cycles; pix_rgb repeats once; underrun_cnt=1.
- clear_req with 2 FIFO entries queued -> DRAIN writes both, then 300 writes of 0 to addrs 0..299; clear_busy drops the cycle after addr 299; wr_ready=0 throughout.
- wr_addr=300 pushed -> popped, no RAM write, next entry proceeds.
- Assert reset_key=0 mid-clear at addr 100 -> clear_busy=0 immediately, outputs zero; after release, FSM IDLE, no further clear writes.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port tile RAM between VGA scan-out reads,
// FIFO-buffered game-logic tile writes and a whole-screen clear sequence.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | normal operation, FIFO writes use free slots
// S_DRAIN | clear requested, flushing queued FIFO writes first
// S_CLEAR | writing CLEAR_VALUE to tiles 0..TILES-1, one per granted slot
module vram_arbiter #(
  parameter int TILE_SHIFT = 5,
  parameter int TILES_X    = 20,
  parameter int TILES_Y    = 15,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clock_50,
  input  logic              reset_key,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_rgb,
  output logic [7:0]        underrun_cnt
);

  localparam int TILES  = TILES_X * TILES_Y;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [7:0]        under_q, under_d;
  logic              rd_pend_q, rd_pend_d;
  logic              blank_pend_q, blank_pend_d;

  logic              disp, fifo_empty, fifo_full, push, pop;
  logic              pend, starved, grant, preempt, clr_grant;
  logic [ADDR_W-1:0] tile_idx, head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_in_range;

  // Slot classification, grant decision and tile index for the current pixel
  always_comb begin
    disp          = p_tick && video_on;
    fifo_empty    = (count_q == '0);
    fifo_full     = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    clear_busy    = (state_q != S_IDLE);
    wr_ready      = !fifo_full && !clear_busy;
    push          = wr_valid && wr_ready;
    head_addr     = fifo_addr_q[rd_ptr_q];
    head_data     = fifo_data_q[rd_ptr_q];
    head_in_range = (32'(head_addr) < 32'(TILES));
    // Only entries already stored count as pending: no same-cycle bypass.
    pend          = (state_q == S_CLEAR) || !fifo_empty;
    starved       = (wait_q == WAIT_W'(MAX_WAIT));
    grant         = pend && (!disp || starved);
    preempt       = grant && disp;
    clr_grant     = grant && (state_q == S_CLEAR);
    pop           = grant && (state_q != S_CLEAR);
    tile_idx      = ADDR_W'(pixel_y >> TILE_SHIFT) * ADDR_W'(TILES_X)
                  + ADDR_W'(pixel_x >> TILE_SHIFT);
  end

  // RAM port mux: clear beats FIFO; out-of-range FIFO entries pop without a write
  always_comb begin
    ram_addr  = tile_idx;
    ram_we    = 1'b0;
    ram_wdata = CLEAR_VALUE;
    if (clr_grant) begin
      ram_addr = clr_ptr_q;
      ram_we   = 1'b1;
    end else if (pop) begin
      ram_addr  = head_addr;
      ram_we    = head_in_range;
      ram_wdata = head_data;
    end
  end

  // FIFO occupancy, starvation counter, underrun counter and pixel pipeline
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    wait_d = wait_q;
    if (grant || !pend) wait_d = '0;
    else if (!starved)  wait_d = wait_q + 1'b1;

    under_d = under_q;
    if (preempt && (under_q != 8'hFF)) under_d = under_q + 1'b1;

    rd_pend_d    = disp && !preempt;
    blank_pend_d = p_tick && !video_on;

    pix_d = pix_q;
    if (rd_pend_q)         pix_d = ram_rdata;
    else if (blank_pend_q) pix_d = '0;
  end

  // Clear sequencer next state
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      S_IDLE:  if (clear_req) state_d = (count_d != '0) ? S_DRAIN : S_CLEAR;
      S_DRAIN: if (count_d == '0) state_d = S_CLEAR;
      S_CLEAR: begin
        if (clr_grant) begin
          if (clr_ptr_q == ADDR_W'(TILES - 1)) begin
            state_d   = S_IDLE;
            clr_ptr_d = '0;
          end else begin
            clr_ptr_d = clr_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage, written only on push
  always_ff @(posedge clock_50) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control and output registers
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      wait_q       <= '0;
      clr_ptr_q    <= '0;
      pix_q        <= '0;
      under_q      <= '0;
      rd_pend_q    <= 1'b0;
      blank_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q      <= count_d;
      wait_q       <= wait_d;
      clr_ptr_q    <= clr_ptr_d;
      pix_q        <= pix_d;
      under_q      <= under_d;
      rd_pend_q    <= rd_pend_d;
      blank_pend_q <= blank_pend_d;
    end
  end

  assign pix_rgb      = pix_q;
  assign underrun_cnt = under_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: behavioural RAM plus a transaction-level
// reference model (queue FIFO, slot grant rules, clear counter).
module tb_vram_arbiter;
  localparam int TILES = 300;
  localparam int MAXW  = 8;

  logic       clock_50 = 1'b0;
  logic       reset_key = 1'b0;
  logic       p_tick = 1'b0, video_on = 1'b0, wr_valid = 1'b0, clear_req = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic [8:0] wr_addr = '0;
  logic [2:0] wr_data = '0;
  logic       wr_ready, clear_busy, ram_we;
  logic [8:0] ram_addr;
  logic [2:0] ram_wdata, ram_rdata, pix_rgb;
  logic [7:0] underrun_cnt;

  logic [2:0] mem [512];

  int n_assert = 0;
  int n_fail   = 0;

  // model state: 0 idle, 1 draining, 2 clearing
  int          m_state = 0, m_clr = 0, m_wait = 0, m_under = 0;
  logic [2:0]  m_pix = '0;
  bit          m_sched = 0;
  logic [2:0]  m_sched_val = '0;
  logic [11:0] m_q [$];
  int          obs_clr_wr = 0;

  vram_arbiter dut (
    .clock_50(clock_50), .reset_key(reset_key), .p_tick(p_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_rgb(pix_rgb), .underrun_cnt(underrun_cnt)
  );

  always #5 clock_50 = ~clock_50;

  // synchronous single-port RAM, read data valid the cycle after the address
  always @(posedge clock_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] tile(input logic [9:0] x, input logic [9:0] y);
    int t;
    t = (int'(y) / 32) * 20 + int'(x) / 32;
    return 9'(t);
  endfunction

  // one clock cycle: drive, check at negedge, advance the model, wait for the edge
  task automatic step(input logic pt, input logic vo, input logic [9:0] px, input logic [9:0] py,
                      input logic wv, input logic [8:0] wa, input logic [2:0] wd, input logic cr);
    int          st0;
    logic        disp, pend, grant, exp_we, rdy;
    logic [8:0]  exp_addr, t_idx;
    logic [2:0]  exp_data;
    logic [11:0] head;
    p_tick = pt; video_on = vo; pixel_x = px; pixel_y = py;
    wr_valid = wv; wr_addr = wa; wr_data = wd; clear_req = cr;
    @(negedge clock_50);
    st0 = m_state;
    chk("pix_rgb", 32'(pix_rgb), 32'(m_pix));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
    chk("clear_busy", 32'(clear_busy), 32'(m_state != 0));
    rdy = (m_q.size() < 4) && (m_state == 0);
    chk("wr_ready", 32'(wr_ready), 32'(rdy));

    disp  = pt && vo;
    pend  = (m_state == 2) || (m_q.size() > 0);
    grant = pend && (!disp || m_wait == MAXW);
    t_idx = tile(px, py);
    exp_we = 1'b0; exp_addr = t_idx; exp_data = '0;
    if (grant && m_state == 2) begin
      exp_we = 1'b1; exp_addr = 9'(m_clr); exp_data = '0;
    end else if (grant) begin
      head = m_q[0];
      exp_we = int'(head[11:3]) < TILES; exp_addr = head[11:3]; exp_data = head[2:0];
    end
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    if (exp_we || (disp && !grant)) chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
    if (exp_we) chk("ram_wdata", 32'(ram_wdata), 32'(exp_data));
    if (st0 == 2 && ram_we === 1'b1 && ram_wdata === 3'd0) obs_clr_wr++;

    if (m_sched) m_pix = m_sched_val;
    m_sched = 0;
    if (disp && !grant) begin m_sched = 1; m_sched_val = mem[t_idx]; end
    else if (pt && !vo) begin m_sched = 1; m_sched_val = '0; end
    if (grant && disp && m_under < 255) m_under++;
    if (grant) m_wait = 0; else if (pend) m_wait++; else m_wait = 0;
    if (grant) begin
      if (m_state == 2) begin
        if (m_clr == TILES - 1) begin m_state = 0; m_clr = 0; end
        else m_clr++;
      end else begin
        void'(m_q.pop_front());
        if (m_state == 1 && m_q.size() == 0) m_state = 2;
      end
    end
    if (wv && rdy) m_q.push_back({wa, wd});
    if (cr && st0 == 0) m_state = (m_q.size() > 0) ? 1 : 2;
    @(posedge clock_50);
    #1;
  endtask

  task automatic model_reset();
    m_state = 0; m_clr = 0; m_wait = 0; m_under = 0; m_pix = '0; m_sched = 0;
    m_q.delete();
  endtask

  task automatic drain_fifo();
    for (int i = 0; i < 40 && m_q.size() > 0; i++)
      step(1'b0, 1'b1, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 512; i++) mem[i] <= 3'($urandom);
    mem[0]   <= 3'd5;
    mem[300] <= 3'd2;

    reset_key = 1'b0;
    repeat (2) @(posedge clock_50);
    #1;
    chk("rst_pix", 32'(pix_rgb), 32'd0);
    chk("rst_under", 32'(underrun_cnt), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    reset_key = 1'b1;

    // idle display of tile 0, p_tick every second cycle
    for (int i = 0; i < 20; i++)
      step(1'(i % 2 == 0), 1'b1, 10'($urandom_range(0, 31)), 10'($urandom_range(0, 31)),
           1'b0, '0, '0, 1'b0);
    chk("s1_pix_tile0", 32'(pix_rgb), 32'd5);

    // fill FIFO during display slots, then drain in free slots
    step(1'b1, 1'b1, 10'd100, 10'd100, 1'b1, 9'd21, 3'd3, 1'b0);
    step(1'b1, 1'b1, 10'd100, 10'd100, 1'b1, 9'd40, 3'($urandom), 1'b0);
    step(1'b1, 1'b1, 10'd100, 10'd100, 1'b1, 9'd41, 3'($urandom), 1'b0);
    step(1'b1, 1'b1, 10'd100, 10'd100, 1'b1, 9'd42, 3'($urandom), 1'b0);
    chk("s2_full_wr_ready", 32'(wr_ready), 32'd0);
    step(1'b1, 1'b1, 10'd100, 10'd100, 1'b1, 9'd43, 3'd1, 1'b0);
    for (int i = 0; i < 12; i++)
      step(1'(i % 2 == 1), 1'b1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
           1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 10'($urandom_range(32, 63)), 10'($urandom_range(32, 63)),
           1'b0, '0, '0, 1'b0);
    chk("s2_pix_32_32", 32'(pix_rgb), 32'd3);

    // starvation: continuous display slots with one pending write
    step(1'b1, 1'b1, 10'd200, 10'd200, 1'b1, 9'd50, 3'd6, 1'b0);
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
           1'b0, '0, '0, 1'b0);
    chk("s3_underrun", 32'(underrun_cnt), 32'd1);
    chk("s3_mem50", 32'(mem[50]), 32'd6);

    // out-of-range entry is dropped, following entry still written
    step(1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 9'd300, 3'd1, 1'b0);
    step(1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 9'd60, 3'd7, 1'b0);
    for (int i = 0; i < 6; i++) step(1'(i % 2 == 1), 1'b1, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("s4_mem60", 32'(mem[60]), 32'd7);
    chk("s4_mem300", 32'(mem[300]), 32'd2);

    // randomized traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom % 2), 1'($urandom % 4 != 0),
           10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
           1'($urandom % 3 == 0), 9'($urandom_range(0, 310)), 3'($urandom), 1'b0);

    // clear with two entries queued
    drain_fifo();
    step(1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 9'd70, 3'd4, 1'b0);
    step(1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 9'd71, 3'd5, 1'b0);
    obs_clr_wr = 0;
    step(1'b1, 1'b1, 10'd0, 10'd0, 1'b0, '0, '0, 1'b1);
    guard = 0;
    while (m_state != 0 && guard < 1000) begin
      step(1'(guard % 2 == 0), 1'b1, 10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
           1'($urandom % 2), 9'($urandom_range(0, 299)), 3'($urandom), 1'($urandom % 8 == 0));
      guard++;
    end
    chk("s6_clear_done_in_time", 32'(guard < 1000), 32'd1);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk("s6_clear_writes", 32'(obs_clr_wr), 32'd300);
    chk("s6_mem70", 32'(mem[70]), 32'd0);
    chk("s6_mem299", 32'(mem[299]), 32'd0);

    // reset in the middle of a clear
    drain_fifo();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    guard = 0;
    while (m_clr < 100 && guard < 400) begin
      step(1'(guard % 2 == 0), 1'b1, 10'd40, 10'd40, 1'b0, '0, '0, 1'b0);
      guard++;
    end
    chk("s7_reached_100", 32'(m_clr), 32'd100);
    reset_key = 1'b0;
    #1;
    chk("s7_busy", 32'(clear_busy), 32'd0);
    chk("s7_pix", 32'(pix_rgb), 32'd0);
    chk("s7_under", 32'(underrun_cnt), 32'd0);
    chk("s7_ram_we", 32'(ram_we), 32'd0);
    model_reset();
    #2;
    reset_key = 1'b1;
    for (int i = 0; i < 20; i++) step(1'(i % 2 == 0), 1'b1, 10'd300, 10'd300, 1'b0, '0, '0, 1'b0);
    chk("s7_mem150_untouched", 32'(mem[150] === 3'd0 ? 1 : 0) | 32'(obs_clr_wr == 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
